// File: rtl/alu_div.sv
// rtl/alu_div.sv - radix-2 restoring 32-bit divider (DIV/DIVU/REM/REMU), RISC-V M semantics
// Optional ALU_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish on the accept edge.
module alu_div #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_valid,
  input  logic            i_result_ready,
  output logic [XLEN-1:0] o_result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_e;

  localparam logic [5:0] LAST_ITER = 6'(XLEN - 1);

  state_e            state_q, state_d;
  logic              rem_sel_q, rem_sel_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_neg, b_neg, div_zero;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [XLEN:0]     shifted, trial;
`ifdef ALU_DIV_EARLY_OUT_EN
  logic              sovf;
`endif

  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = (state_q == S_DONE);
  assign o_result = result_q;

  always_comb begin
    a_neg    = ~i_op[0] & i_dividend[XLEN-1];
    b_neg    = ~i_op[0] & i_divisor[XLEN-1];
    a_abs    = a_neg ? -i_dividend : i_dividend;
    b_abs    = b_neg ? -i_divisor : i_divisor;
    div_zero = (i_divisor == '0);
    shifted  = {rem_q, quo_q[XLEN-1]};
    trial    = shifted - {1'b0, divisor_q};
`ifdef ALU_DIV_EARLY_OUT_EN
    sovf     = ~i_op[0] & (i_dividend == {1'b1, {(XLEN-1){1'b0}}}) & (i_divisor == '1);
`endif

    state_d   = state_q;
    rem_sel_d = rem_sel_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (i_valid && !i_flush) begin
          rem_sel_d = i_op[1];
          // A zero divisor must keep the all-ones quotient, so it never negates.
          qneg_d    = (a_neg ^ b_neg) & ~div_zero;
          rneg_d    = a_neg;
          divisor_d = b_abs;
          quo_d     = a_abs;
          rem_d     = '0;
          cnt_d     = '0;
          state_d   = S_CALC;
`ifdef ALU_DIV_EARLY_OUT_EN
          if (div_zero || sovf) begin
            state_d  = S_DONE;
            result_d = div_zero ? (i_op[1] ? i_dividend : '1)
                                : (i_op[1] ? '0 : i_dividend);
          end
`endif
        end
      end
      S_CALC: begin
        if (!trial[XLEN]) begin
          rem_d = trial[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = shifted[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        if (cnt_q == LAST_ITER) begin
          cnt_d   = '0;
          state_d = S_FIXUP;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_FIXUP: begin
        result_d = rem_sel_q ? (rneg_q ? -rem_q : rem_q)
                             : (qneg_q ? -quo_q : quo_q);
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (i_result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (i_flush) state_d = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      rem_sel_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      rem_sel_q <= rem_sel_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_div.sv
// tb/tb_alu_div.sv - self-checking bench for alu_div against an arithmetic reference model
module tb_alu_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [1:0]  op = 2'd0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] result;

  int total = 0;
  int bad = 0;

`ifdef ALU_DIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 0;
`else
  localparam int SPECIAL_LAT = 33;
`endif

  alu_div #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(ready),
    .i_op(op), .i_dividend(dividend), .i_divisor(divisor), .o_valid(res_valid),
    .i_result_ready(res_ready), .o_result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
    case (o)
      2'd0:    return 32'(sa / sb);
      2'd1:    return a / b;
      2'd2:    return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  // Issue one request, measure edges from accept to o_valid, hold the result, then consume it.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int n;
    int lat;
    logic [31:0] exp;
    exp = ref_model(o, a, b);
    n = 0;
    while (!ready && n < 100) begin @(negedge clk); n++; end
    check({tag, "_ready"}, 32'(ready), 32'd1);
    valid = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    valid = 1'b0; op = $urandom; dividend = $urandom; divisor = $urandom;
    lat = 0;
    while (!res_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check({tag, "_lat"}, 32'(lat), is_special(o, a, b) ? 32'(SPECIAL_LAT) : 32'd33);
    check({tag, "_res"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_res"}, result, exp);
      check({tag, "_hold_bsy"}, {30'd0, ready, res_valid}, 32'd1);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, "_consumed"}, {30'd0, ready, res_valid}, 32'd2);
    @(negedge clk);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", 32'(res_valid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_ready", 32'(ready), 32'd1);

    run_op("divu_100_7", 2'd1, 32'd100, 32'd7, 0);
    run_op("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("remu_fff9_2", 2'd3, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("div_5_0", 2'd0, 32'd5, 32'd0, 0);
    run_op("rem_5_0", 2'd2, 32'd5, 32'd0, 0);
    run_op("div_m5_0", 2'd0, 32'hFFFF_FFFB, 32'd0, 0);
    run_op("remu_m5_0", 2'd3, 32'hFFFF_FFFB, 32'd0, 0);
    run_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_min_m1", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    run_op("backpressure", 2'd1, 32'd1000, 32'd9, 10);
    run_op("after_bp", 2'd0, 32'd77, 32'hFFFF_FFF5, 0);

    // Flush mid-CALC: accept at t, flush sampled on edge t+10.
    valid = 1'b1; op = 2'd1; dividend = 32'd12345; divisor = 32'd11;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", {30'd0, ready, res_valid}, 32'd2);
    watch_no_valid("flush_no_valid", 40);
    run_op("divu_9_3", 2'd1, 32'd9, 32'd3, 0);

    // Reset mid-CALC with a request pending.
    valid = 1'b1; op = 2'd1; dividend = 32'hFFFF_FFFF; divisor = 32'd3;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1; valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst_ready_valid", {30'd0, ready, res_valid}, 32'd2);
      check("rst_result", result, 32'd0);
    end
    rst = 1'b0; valid = 1'b0;
    watch_no_valid("rst_no_valid", 40);
    check("rst_after_ready", 32'(ready), 32'd1);

    for (int k = 0; k < 40; k++) begin
      r_op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       r_a = 32'd0;
        1:       r_a = 32'hFFFF_FFFF;
        2:       r_a = 32'h8000_0000;
        default: r_a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       r_b = 32'd0;
        1:       r_b = 32'hFFFF_FFFF;
        2:       r_b = 32'($urandom_range(1, 20));
        default: r_b = $urandom;
      endcase
      run_op("rand", r_op, r_a, r_b, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
